// File: rtl/ans_delay_tick_ctrl.sv
// Answer-delay control: starts the delay counter after the last tx byte, issues the
// 0.1 ms acquisition tick, and freezes/latches the count on the first rx start bit.
module ans_delay_tick_ctrl #(
    parameter int CLK_DIV     = 4000,
    parameter int DIV_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Enable_i,
    input  logic        TxFrameDone_i,
    input  logic        Rx_i,
    input  logic        ClrCnt_i,
    input  logic        p_TimeOut_i,
    input  logic [15:0] TimeCnt_i,
    output logic        AcqSig_o,
    output logic        p_TimeCntStartSig_o,
    output logic        p_TimeCntHoldSig_o,
    output logic        p_TimeCntResetSig_o,
    output logic [15:0] AnsDelay_o,
    output logic        p_AnsValid_o,
    output logic        p_AnsTimeout_o,
    output logic        Busy_o
);

    typedef enum logic [1:0] {IDLE, WAIT, CAPTURE} state_t;

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    state_t                 r_state;
    logic [DIV_W-1:0]       r_presc;
    logic [1:0]             r_guard;
    logic                   r_cap;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rx_d;
    logic                   w_rx_s;
    logic                   w_fall;
    logic                   w_wrap;

    assign w_rx_s = r_sync[SYNC_STAGES-1];
    assign w_fall = r_rx_d & ~w_rx_s;
    assign w_wrap = (r_presc == DIV_MAX);
    assign Busy_o = (r_state != IDLE);

    // Idle-high line: preset the synchroniser so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '1;
            r_rx_d <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], Rx_i};
            r_rx_d <= w_rx_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state             <= IDLE;
            r_presc             <= '0;
            r_guard             <= '0;
            r_cap               <= 1'b0;
            AcqSig_o            <= 1'b0;
            p_TimeCntStartSig_o <= 1'b0;
            p_TimeCntHoldSig_o  <= 1'b0;
            p_TimeCntResetSig_o <= 1'b0;
            p_AnsValid_o        <= 1'b0;
            p_AnsTimeout_o      <= 1'b0;
            AnsDelay_o          <= '0;
        end else begin
            AcqSig_o            <= 1'b0;
            p_TimeCntStartSig_o <= 1'b0;
            p_TimeCntHoldSig_o  <= 1'b0;
            p_TimeCntResetSig_o <= 1'b0;
            p_AnsValid_o        <= 1'b0;
            p_AnsTimeout_o      <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_presc <= '0;
                    if (Enable_i && TxFrameDone_i) begin
                        p_TimeCntStartSig_o <= 1'b1;
                        r_guard             <= '0;
                        r_state             <= WAIT;
                    end else if (ClrCnt_i) begin
                        p_TimeCntResetSig_o <= 1'b1;
                    end
                end
                WAIT: begin
                    if (!Enable_i) begin
                        p_TimeCntHoldSig_o <= 1'b1;
                        r_presc            <= '0;
                        r_state            <= IDLE;
                    end else if (TxFrameDone_i) begin
                        p_TimeCntStartSig_o <= 1'b1;
                        AcqSig_o            <= w_wrap;
                        r_presc             <= '0;
                        r_guard             <= '0;
                    end else if (w_fall) begin
                        p_TimeCntHoldSig_o <= 1'b1;
                        r_presc            <= '0;
                        r_cap              <= 1'b0;
                        r_state            <= CAPTURE;
                    end else if (p_TimeOut_i && r_guard == 2'd2) begin
                        p_TimeCntHoldSig_o <= 1'b1;
                        p_AnsTimeout_o     <= 1'b1;
                        r_presc            <= '0;
                        r_state            <= IDLE;
                    end else begin
                        AcqSig_o <= w_wrap;
                        r_presc  <= w_wrap ? '0 : r_presc + DIV_W'(1);
                        // Timeout is masked until the counter has cleared and settled.
                        if (r_guard != 2'd2) r_guard <= r_guard + 2'd1;
                    end
                end
                CAPTURE: begin
                    r_presc <= '0;
                    if (r_cap) begin
                        AnsDelay_o   <= TimeCnt_i;
                        p_AnsValid_o <= 1'b1;
                        r_state      <= IDLE;
                    end else begin
                        r_cap <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
